// File: rtl/at_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS-style pipeline: register-hazard stalls,
// D/E/M forwarding selects, mult/div busy interlock and eret-after-mtc0 interlock.
module at_hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RA1_ID,
    input  logic [4:0] RA2_ID,
    input  logic [4:0] WA_ID,
    input  logic [1:0] Tuse_RA1,
    input  logic [1:0] Tuse_RA2,
    input  logic [1:0] Tnew,
    input  logic       md_use_ID,
    input  logic       md_start_ID,
    input  logic       md_is_div_ID,
    input  logic [4:0] c0_WA_ID,
    input  logic       eret_ID,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] FwdD1,
    output logic [1:0] FwdD2,
    output logic [1:0] FwdE1,
    output logic [1:0] FwdE2,
    output logic       FwdM2
);

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;
    localparam logic [4:0] EPC_REG    = 5'd14;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Producer result is ready now and targets a real register r.
    function automatic logic fwd_hit(input logic [4:0] r, input logic [4:0] wa,
                                     input logic [1:0] tn);
        return (r != 5'd0) && (r == wa) && (tn == 2'd0);
    endfunction

    // Producer result arrives later than the consumer needs it.
    function automatic logic too_late(input logic [4:0] r, input logic [4:0] wa,
                                      input logic [1:0] tn, input logic [1:0] tuse);
        return (r != 5'd0) && (r == wa) && (tn > tuse);
    endfunction

    // Fields with no downstream consumer are not carried into later stages.
    logic [4:0] ra1_e_q, ra1_e_d;
    logic [4:0] ra2_e_q, ra2_e_d;
    logic [4:0] wa_e_q, wa_e_d;
    logic [1:0] tnew_e_q, tnew_e_d;
    logic [4:0] c0_wa_e_q, c0_wa_e_d;
    logic       md_start_e_q, md_start_e_d;
    logic       md_is_div_e_q, md_is_div_e_d;

    logic [4:0] ra2_m_q, ra2_m_d;
    logic [4:0] wa_m_q, wa_m_d;
    logic [1:0] tnew_m_q, tnew_m_d;
    logic [4:0] c0_wa_m_q, c0_wa_m_d;

    logic [4:0] wa_w_q, wa_w_d;
    logic [1:0] tnew_w_q, tnew_w_d;

    logic [3:0] cnt_q, cnt_d;

    logic stall_ra1, stall_ra2, stall_md, stall_eret, md_busy;

    assign stall_ra1  = too_late(RA1_ID, wa_e_q, tnew_e_q, Tuse_RA1) ||
                        too_late(RA1_ID, wa_m_q, tnew_m_q, Tuse_RA1);
    assign stall_ra2  = too_late(RA2_ID, wa_e_q, tnew_e_q, Tuse_RA2) ||
                        too_late(RA2_ID, wa_m_q, tnew_m_q, Tuse_RA2);
    assign md_busy    = md_start_e_q || (cnt_q != 4'd0);
    assign stall_md   = md_use_ID && md_busy;
    assign stall_eret = eret_ID && ((c0_wa_e_q == EPC_REG) || (c0_wa_m_q == EPC_REG));
    assign stall      = !flush && (stall_ra1 || stall_ra2 || stall_md || stall_eret);

    always_comb begin : stage_next
        ra1_e_d       = RA1_ID;
        ra2_e_d       = RA2_ID;
        wa_e_d        = WA_ID;
        tnew_e_d      = Tnew;
        c0_wa_e_d     = c0_WA_ID;
        md_start_e_d  = md_start_ID;
        md_is_div_e_d = md_is_div_ID;

        ra2_m_d   = ra2_e_q;
        wa_m_d    = wa_e_q;
        tnew_m_d  = sat_dec(tnew_e_q);
        c0_wa_m_d = c0_wa_e_q;

        wa_w_d   = wa_m_q;
        tnew_w_d = sat_dec(tnew_m_q);

        if (flush) begin
            ra1_e_d       = 5'd0;
            ra2_e_d       = 5'd0;
            wa_e_d        = 5'd0;
            tnew_e_d      = 2'd0;
            c0_wa_e_d     = 5'd0;
            md_start_e_d  = 1'b0;
            md_is_div_e_d = 1'b0;
            ra2_m_d       = 5'd0;
            wa_m_d        = 5'd0;
            tnew_m_d      = 2'd0;
            c0_wa_m_d     = 5'd0;
            wa_w_d        = 5'd0;
            tnew_w_d      = 2'd0;
        end else if (stall) begin
            ra1_e_d       = 5'd0;
            ra2_e_d       = 5'd0;
            wa_e_d        = 5'd0;
            tnew_e_d      = 2'd0;
            c0_wa_e_d     = 5'd0;
            md_start_e_d  = 1'b0;
            md_is_div_e_d = 1'b0;
        end
    end

    // The busy count keeps running across a flush; only reset aborts it.
    always_comb begin : md_next
        cnt_d = cnt_q;
        if (md_start_e_q) begin
            cnt_d = md_is_div_e_q ? DIV_CYCLES : MUL_CYCLES;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1_e_q       <= 5'd0;
            ra2_e_q       <= 5'd0;
            wa_e_q        <= 5'd0;
            tnew_e_q      <= 2'd0;
            c0_wa_e_q     <= 5'd0;
            md_start_e_q  <= 1'b0;
            md_is_div_e_q <= 1'b0;
            ra2_m_q       <= 5'd0;
            wa_m_q        <= 5'd0;
            tnew_m_q      <= 2'd0;
            c0_wa_m_q     <= 5'd0;
            wa_w_q        <= 5'd0;
            tnew_w_q      <= 2'd0;
            cnt_q         <= 4'd0;
        end else begin
            ra1_e_q       <= ra1_e_d;
            ra2_e_q       <= ra2_e_d;
            wa_e_q        <= wa_e_d;
            tnew_e_q      <= tnew_e_d;
            c0_wa_e_q     <= c0_wa_e_d;
            md_start_e_q  <= md_start_e_d;
            md_is_div_e_q <= md_is_div_e_d;
            ra2_m_q       <= ra2_m_d;
            wa_m_q        <= wa_m_d;
            tnew_m_q      <= tnew_m_d;
            c0_wa_m_q     <= c0_wa_m_d;
            wa_w_q        <= wa_w_d;
            tnew_w_q      <= tnew_w_d;
            cnt_q         <= cnt_d;
        end
    end

    // Youngest matching producer is tested first so it shadows older writers.
    always_comb begin : fwd_sel
        FwdD1 = 2'd0;
        if (fwd_hit(RA1_ID, wa_e_q, tnew_e_q))      FwdD1 = 2'd1;
        else if (fwd_hit(RA1_ID, wa_m_q, tnew_m_q)) FwdD1 = 2'd2;
        else if (fwd_hit(RA1_ID, wa_w_q, tnew_w_q)) FwdD1 = 2'd3;

        FwdD2 = 2'd0;
        if (fwd_hit(RA2_ID, wa_e_q, tnew_e_q))      FwdD2 = 2'd1;
        else if (fwd_hit(RA2_ID, wa_m_q, tnew_m_q)) FwdD2 = 2'd2;
        else if (fwd_hit(RA2_ID, wa_w_q, tnew_w_q)) FwdD2 = 2'd3;

        FwdE1 = 2'd0;
        if (fwd_hit(ra1_e_q, wa_m_q, tnew_m_q))      FwdE1 = 2'd1;
        else if (fwd_hit(ra1_e_q, wa_w_q, tnew_w_q)) FwdE1 = 2'd2;

        FwdE2 = 2'd0;
        if (fwd_hit(ra2_e_q, wa_m_q, tnew_m_q))      FwdE2 = 2'd1;
        else if (fwd_hit(ra2_e_q, wa_w_q, tnew_w_q)) FwdE2 = 2'd2;

        FwdM2 = fwd_hit(ra2_m_q, wa_w_q, tnew_w_q);
    end

endmodule
